// File: rtl/instr_encoder_pkg.sv
// Shared constants for the AVR (ATtiny20 subset) instruction encoder: one-hot
// instruction types, opcode prefixes/suffixes, fixed words and FSM states.
package instr_encoder_pkg;

    localparam int INSTR_WIDTH   = 16;
    localparam int R_ADDR_WIDTH  = 5;
    localparam int PM_ADDR_WIDTH = 10;
    localparam int IMD_WIDTH     = 12;
    localparam int OPCODE_COUNT  = 21;

    typedef logic [OPCODE_COUNT-1:0] opcode_t;

    // One-hot instruction types, identical to the decoder's output encoding
    localparam opcode_t TYPE_ADD     = opcode_t'(1 << 0);
    localparam opcode_t TYPE_ADC     = opcode_t'(1 << 1);
    localparam opcode_t TYPE_SUB     = opcode_t'(1 << 2);
    localparam opcode_t TYPE_AND     = opcode_t'(1 << 3);
    localparam opcode_t TYPE_EOR     = opcode_t'(1 << 4);
    localparam opcode_t TYPE_OR      = opcode_t'(1 << 5);
    localparam opcode_t TYPE_MOV     = opcode_t'(1 << 6);
    localparam opcode_t TYPE_BRBS    = opcode_t'(1 << 7);
    localparam opcode_t TYPE_BRBC    = opcode_t'(1 << 8);
    localparam opcode_t TYPE_LD_Y    = opcode_t'(1 << 9);
    localparam opcode_t TYPE_POP     = opcode_t'(1 << 10);
    localparam opcode_t TYPE_PUSH    = opcode_t'(1 << 11);
    localparam opcode_t TYPE_NEG     = opcode_t'(1 << 12);
    localparam opcode_t TYPE_LDI     = opcode_t'(1 << 13);
    localparam opcode_t TYPE_LDS     = opcode_t'(1 << 14);
    localparam opcode_t TYPE_STS     = opcode_t'(1 << 15);
    localparam opcode_t TYPE_RJMP    = opcode_t'(1 << 16);
    localparam opcode_t TYPE_RCALL   = opcode_t'(1 << 17);
    localparam opcode_t TYPE_RET     = opcode_t'(1 << 18);
    localparam opcode_t TYPE_NOP     = opcode_t'(1 << 19);
    localparam opcode_t TYPE_UNKNOWN = opcode_t'(1 << 20);

    localparam logic [5:0] OPC_ADD_PREFIX   = 6'b000011;
    localparam logic [5:0] OPC_ADC_PREFIX   = 6'b000111;
    localparam logic [5:0] OPC_SUB_PREFIX   = 6'b000110;
    localparam logic [5:0] OPC_AND_PREFIX   = 6'b001000;
    localparam logic [5:0] OPC_EOR_PREFIX   = 6'b001001;
    localparam logic [5:0] OPC_OR_PREFIX    = 6'b001010;
    localparam logic [5:0] OPC_MOV_PREFIX   = 6'b001011;
    localparam logic [5:0] OPC_BRBS_PREFIX  = 6'b111100;
    localparam logic [5:0] OPC_BRBC_PREFIX  = 6'b111101;
    localparam logic [6:0] OPC_LD_Y_PREFIX  = 7'b1000000;
    localparam logic [6:0] OPC_POP_PREFIX   = 7'b1001000;
    localparam logic [6:0] OPC_PUSH_PREFIX  = 7'b1001001;
    localparam logic [6:0] OPC_NEG_PREFIX   = 7'b1001010;
    localparam logic [3:0] OPC_LD_Y_SUFFIX  = 4'b1000;
    localparam logic [3:0] OPC_POP_SUFFIX   = 4'b1111;
    localparam logic [3:0] OPC_PUSH_SUFFIX  = 4'b1111;
    localparam logic [3:0] OPC_NEG_SUFFIX   = 4'b0001;
    localparam logic [3:0] OPC_LDI_PREFIX   = 4'b1110;
    localparam logic [4:0] OPC_LDS_PREFIX   = 5'b10100;
    localparam logic [4:0] OPC_STS_PREFIX   = 5'b10101;
    localparam logic [3:0] OPC_RJMP_PREFIX  = 4'b1100;
    localparam logic [3:0] OPC_RCALL_PREFIX = 4'b1101;

    localparam logic [INSTR_WIDTH-1:0] WORD_RET = 16'h9508;
    localparam logic [INSTR_WIDTH-1:0] WORD_NOP = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // Two-register ALU form: rr is split around rd
    function automatic logic [INSTR_WIDTH-1:0] rr_form(
        input logic [5:0]              prefix,
        input logic [R_ADDR_WIDTH-1:0] rd,
        input logic [R_ADDR_WIDTH-1:0] rr
    );
        return {prefix, rr[4], rd, rr[3:0]};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Decoded-field bundle handshake between a field source and the encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    opcode_t                 in_type;
    logic [R_ADDR_WIDTH-1:0] in_rd;
    logic [R_ADDR_WIDTH-1:0] in_rr;
    logic [IMD_WIDTH-1:0]    in_imd;
    logic [2:0]              in_bit;

    modport master (
        output in_valid, in_last, in_type, in_rd, in_rr, in_imd, in_bit,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_type, in_rd, in_rr, in_imd, in_bit,
        output in_ready
    );

endinterface

// File: rtl/instr_encode_core.sv
// Combinational field packer: decoded fields -> 16-bit instruction word plus
// a flag for bundles the decoder could never have produced.
module instr_encode_core
    import instr_encoder_pkg::*;
(
    input  opcode_t                 in_type,
    input  logic [R_ADDR_WIDTH-1:0] rd,
    input  logic [R_ADDR_WIDTH-1:0] rr,
    input  logic [IMD_WIDTH-1:0]    imd,
    input  logic [2:0]              sreg_bit,
    output logic [INSTR_WIDTH-1:0]  word,
    output logic                    illegal
);

    logic brb_ok;
    logic imd_hi_zero;
    logic lds_ok;

    // Branch offsets must be a sign extension of the 7-bit field
    assign brb_ok      = (imd[11:6] == 6'b000000) || (imd[11:6] == 6'b111111);
    assign imd_hi_zero = (imd[11:8] == 4'h0);
    assign lds_ok      = imd_hi_zero && (imd[7] == ~imd[6]);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (in_type)
            TYPE_ADD:   word = rr_form(OPC_ADD_PREFIX, rd, rr);
            TYPE_ADC:   word = rr_form(OPC_ADC_PREFIX, rd, rr);
            TYPE_SUB:   word = rr_form(OPC_SUB_PREFIX, rd, rr);
            TYPE_AND:   word = rr_form(OPC_AND_PREFIX, rd, rr);
            TYPE_EOR:   word = rr_form(OPC_EOR_PREFIX, rd, rr);
            TYPE_OR:    word = rr_form(OPC_OR_PREFIX, rd, rr);
            TYPE_MOV:   word = rr_form(OPC_MOV_PREFIX, rd, rr);
            TYPE_BRBS: begin
                word    = {OPC_BRBS_PREFIX, imd[6:0], sreg_bit};
                illegal = !brb_ok;
            end
            TYPE_BRBC: begin
                word    = {OPC_BRBC_PREFIX, imd[6:0], sreg_bit};
                illegal = !brb_ok;
            end
            TYPE_LD_Y:  word = {OPC_LD_Y_PREFIX, rd, OPC_LD_Y_SUFFIX};
            TYPE_POP:   word = {OPC_POP_PREFIX, rd, OPC_POP_SUFFIX};
            TYPE_PUSH:  word = {OPC_PUSH_PREFIX, rr, OPC_PUSH_SUFFIX};
            TYPE_NEG:   word = {OPC_NEG_PREFIX, rd, OPC_NEG_SUFFIX};
            TYPE_LDI: begin
                word    = {OPC_LDI_PREFIX, imd[7:4], rd[3:0], imd[3:0]};
                illegal = !rd[4] || !imd_hi_zero;
            end
            // 16-bit LDS/STS only reach 0x40..0xBF, so imd[7] is implied by imd[6]
            TYPE_LDS: begin
                word    = {OPC_LDS_PREFIX, imd[5:4], imd[6], rd[3:0], imd[3:0]};
                illegal = !rd[4] || !lds_ok;
            end
            TYPE_STS: begin
                word    = {OPC_STS_PREFIX, imd[5:4], imd[6], rr[3:0], imd[3:0]};
                illegal = !rr[4] || !lds_ok;
            end
            TYPE_RJMP:  word = {OPC_RJMP_PREFIX, imd};
            TYPE_RCALL: word = {OPC_RCALL_PREFIX, imd};
            TYPE_RET:   word = WORD_RET;
            TYPE_NOP:   word = WORD_NOP;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts decoded field bundles, encodes them and writes the
// words to consecutive program memory addresses, one word per two cycles.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PM_ADDR_WIDTH-1:0] base_addr,
    instr_encoder_if.slave           in_bus,
    output logic                     pm_we,
    output logic [PM_ADDR_WIDTH-1:0] pm_addr,
    output logic [INSTR_WIDTH-1:0]   pm_wdata,
    output logic [PM_ADDR_WIDTH:0]   word_count,
    output logic                     done,
    output logic                     err,
    output logic                     wrap
);

    state_t                   state_reg, state_next;
    logic [PM_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                     last_reg, last_next;
    logic                     pm_we_reg, pm_we_next;
    logic [PM_ADDR_WIDTH-1:0] pm_addr_reg, pm_addr_next;
    logic [INSTR_WIDTH-1:0]   pm_wdata_reg, pm_wdata_next;
    logic [PM_ADDR_WIDTH:0]   word_count_reg, word_count_next;
    logic                     done_reg, done_next;
    logic                     err_reg, err_next;
    logic                     wrap_reg, wrap_next;
    logic                     in_ready_c;

    logic [INSTR_WIDTH-1:0]   enc_word;
    logic                     enc_illegal;

    instr_encode_core u_core (
        .in_type  (in_bus.in_type),
        .rd       (in_bus.in_rd),
        .rr       (in_bus.in_rr),
        .imd      (in_bus.in_imd),
        .sreg_bit (in_bus.in_bit),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            last_reg       <= 1'b0;
            pm_we_reg      <= 1'b0;
            pm_addr_reg    <= '0;
            pm_wdata_reg   <= '0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            last_reg       <= last_next;
            pm_we_reg      <= pm_we_next;
            pm_addr_reg    <= pm_addr_next;
            pm_wdata_reg   <= pm_wdata_next;
            word_count_reg <= word_count_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            wrap_reg       <= wrap_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        last_next       = last_reg;
        pm_we_next      = pm_we_reg;
        pm_addr_next    = pm_addr_reg;
        pm_wdata_next   = pm_wdata_reg;
        word_count_next = word_count_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        wrap_next       = wrap_reg;
        in_ready_c      = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next      = ST_ACCEPT;
                    addr_next       = base_addr;
                    word_count_next = '0;
                    done_next       = 1'b0;
                    err_next        = 1'b0;
                    wrap_next       = 1'b0;
                end
            end
            ST_ACCEPT: begin
                in_ready_c = 1'b1;
                if (in_bus.in_valid) begin
                    if (enc_illegal) begin
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                    end else begin
                        pm_wdata_next = enc_word;
                        pm_addr_next  = addr_reg;
                        pm_we_next    = 1'b1;
                        last_next     = in_bus.in_last;
                        state_next    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                pm_we_next      = 1'b0;
                addr_next       = addr_reg + PM_ADDR_WIDTH'(1);
                word_count_next = word_count_reg + (PM_ADDR_WIDTH + 1)'(1);
                if (&addr_reg) begin
                    wrap_next = 1'b1;
                end
                if (last_reg) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_ACCEPT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_bus.in_ready = in_ready_c;
    assign pm_we           = pm_we_reg;
    assign pm_addr         = pm_addr_reg;
    assign pm_wdata        = pm_wdata_reg;
    assign word_count      = word_count_reg;
    assign done            = done_reg;
    assign err             = err_reg;
    assign wrap            = wrap_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: known-answer words, illegal bundles,
// address wrap, mid-write reset and a decoder round-trip over every legal type.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic        pm_we;
    logic [9:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic [10:0] word_count;
    logic        done;
    logic        err;
    logic        wrap;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_bus     (bus.slave),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .word_count (word_count),
        .done       (done),
        .err        (err),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        opcode_t     t;
        logic [4:0]  rd;
        logic [4:0]  rr;
        logic [11:0] imd;
        logic [2:0]  b;
    } fld_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    fld_t fld_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        if (pm_we === 1'b1) obs_q.push_back({pm_addr, pm_wdata});
    end

    function automatic fld_t mk(opcode_t t, logic [4:0] rd, logic [4:0] rr,
                                logic [11:0] imd, logic [2:0] b);
        fld_t f;
        f.t = t; f.rd = rd; f.rr = rr; f.imd = imd; f.b = b;
        return f;
    endfunction

    function automatic opcode_t type_of(int i);
        case (i)
            0: return TYPE_ADD;   1: return TYPE_ADC;   2: return TYPE_SUB;
            3: return TYPE_AND;   4: return TYPE_EOR;   5: return TYPE_OR;
            6: return TYPE_MOV;   7: return TYPE_BRBS;  8: return TYPE_BRBC;
            9: return TYPE_LD_Y;  10: return TYPE_POP;  11: return TYPE_PUSH;
            12: return TYPE_NEG;  13: return TYPE_LDI;  14: return TYPE_LDS;
            15: return TYPE_STS;  16: return TYPE_RJMP; 17: return TYPE_RCALL;
            18: return TYPE_RET;  default: return TYPE_NOP;
        endcase
    endfunction

    // Which decoded fields are meaningful: {rd, rr, imd, bit}
    function automatic logic [3:0] use_mask(opcode_t t);
        case (t)
            TYPE_ADD, TYPE_ADC, TYPE_SUB, TYPE_AND,
            TYPE_EOR, TYPE_OR, TYPE_MOV:   return 4'b1100;
            TYPE_BRBS, TYPE_BRBC:          return 4'b0011;
            TYPE_LD_Y, TYPE_POP, TYPE_NEG: return 4'b1000;
            TYPE_PUSH:                     return 4'b0100;
            TYPE_LDI, TYPE_LDS:            return 4'b1010;
            TYPE_STS:                      return 4'b0110;
            TYPE_RJMP, TYPE_RCALL:         return 4'b0010;
            default:                       return 4'b0000;
        endcase
    endfunction

    function automatic fld_t rand_legal(opcode_t t);
        fld_t       f;
        logic [6:0] s;
        f.t   = t;
        f.rd  = 5'($urandom);
        f.rr  = 5'($urandom);
        f.imd = 12'($urandom);
        f.b   = 3'($urandom);
        s     = 7'($urandom);
        case (t)
            TYPE_BRBS, TYPE_BRBC: f.imd = {{5{s[6]}}, s};
            TYPE_LDI: begin f.rd[4] = 1'b1; f.imd[11:8] = 4'h0; end
            TYPE_LDS: begin f.rd[4] = 1'b1; f.imd = {4'h0, ~s[6], s}; end
            TYPE_STS: begin f.rr[4] = 1'b1; f.imd = {4'h0, ~s[6], s}; end
            default: ;
        endcase
        return f;
    endfunction

    // Reference AVR decoder written from the bit patterns
    function automatic fld_t decode(logic [15:0] w);
        fld_t d;
        d   = '0;
        d.t = TYPE_UNKNOWN;
        if (w == 16'h9508) d.t = TYPE_RET;
        else if (w == 16'h0000) d.t = TYPE_NOP;
        else if (w[15:11] == 5'b11110) begin
            d.t   = w[10] ? TYPE_BRBC : TYPE_BRBS;
            d.imd = {{5{w[9]}}, w[9:3]};
            d.b   = w[2:0];
        end else if (w[15:12] == 4'b1110) begin
            d.t   = TYPE_LDI;
            d.rd  = {1'b1, w[7:4]};
            d.imd = {4'h0, w[11:8], w[3:0]};
        end else if (w[15:13] == 3'b110) begin
            d.t   = w[12] ? TYPE_RCALL : TYPE_RJMP;
            d.imd = w[11:0];
        end else if (w[15:12] == 4'b1010) begin
            d.t   = w[11] ? TYPE_STS : TYPE_LDS;
            if (w[11]) d.rr = {1'b1, w[7:4]};
            else       d.rd = {1'b1, w[7:4]};
            d.imd = {4'h0, ~w[8], w[8], w[10:9], w[3:0]};
        end else if (w[15:9] == 7'b1000000 && w[3:0] == 4'b1000) begin
            d.t = TYPE_LD_Y; d.rd = w[8:4];
        end else if (w[15:9] == 7'b1001000 && w[3:0] == 4'b1111) begin
            d.t = TYPE_POP; d.rd = w[8:4];
        end else if (w[15:9] == 7'b1001001 && w[3:0] == 4'b1111) begin
            d.t = TYPE_PUSH; d.rr = w[8:4];
        end else if (w[15:9] == 7'b1001010 && w[3:0] == 4'b0001) begin
            d.t = TYPE_NEG; d.rd = w[8:4];
        end else if (w[15:14] == 2'b00) begin
            case (w[13:10])
                4'b0011: d.t = TYPE_ADD;
                4'b0111: d.t = TYPE_ADC;
                4'b0110: d.t = TYPE_SUB;
                4'b1000: d.t = TYPE_AND;
                4'b1001: d.t = TYPE_EOR;
                4'b1010: d.t = TYPE_OR;
                4'b1011: d.t = TYPE_MOV;
                default: d.t = TYPE_UNKNOWN;
            endcase
            d.rd = w[8:4];
            d.rr = {w[9], w[3:0]};
        end
        return d;
    endfunction

    task automatic do_start(input logic [9:0] base);
        @(posedge clk); #1;
        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Present one bundle; returns at 1 time unit after the accepting edge
    task automatic send(input fld_t f, input logic last, output logic ok);
        bus.in_type  = f.t;
        bus.in_rd    = f.rd;
        bus.in_rr    = f.rr;
        bus.in_imd   = f.imd;
        bus.in_bit   = f.b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        logic [47:0] observed;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        observed = {pm_we, pm_addr, pm_wdata, word_count, done, err, wrap,
                    bus.in_ready, 6'd0};
        n_checks++;
        if (observed !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected all zero", observed);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got %b, expected 0", bus.in_ready);
        end
    endtask

    task automatic test_single_add();
        logic ok;
        wr_t  e, o;
        do_start(10'h010);
        exp_q.push_back({10'h010, 16'h0F12});
        send(mk(TYPE_ADD, 5'd17, 5'd18, 12'h000, 3'd0), 1'b1, ok);
        n_checks++;
        if (!ok || pm_we !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency: handshake=%b pm_we=%b, expected 1/1", ok, pm_we);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL add_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL add_write: got %h@%h, expected %h@%h", o.data, o.addr, e.data, e.addr);
            end
        end
        n_checks++;
        if ({done, word_count, bus.in_ready} !== {1'b1, 11'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_status: done=%b count=%0d ready=%b, expected 1/1/0",
                     done, word_count, bus.in_ready);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // Multi-word programs: LDI/LDS pair, then BRBS/RCALL/RET back to back
    task automatic test_sequences();
        logic ok;
        wr_t  e, o;
        do_start(10'h000);
        exp_q.push_back({10'h000, 16'hEA45});
        exp_q.push_back({10'h001, 16'hA105});
        send(mk(TYPE_LDI, 5'd20, 5'd0, 12'h0A5, 3'd0), 1'b0, ok);
        send(mk(TYPE_LDS, 5'd16, 5'd0, 12'h045, 3'd0), 1'b1, ok);
        repeat (3) @(posedge clk);
        do_start(10'h100);
        exp_q.push_back({10'h100, 16'hF3F1});
        exp_q.push_back({10'h101, 16'hDFFE});
        exp_q.push_back({10'h102, 16'h9508});
        send(mk(TYPE_BRBS, 5'd0, 5'd0, 12'hFFE, 3'd1), 1'b0, ok);
        send(mk(TYPE_RCALL, 5'd0, 5'd0, 12'hFFE, 3'd0), 1'b0, ok);
        send(mk(TYPE_RET, 5'd0, 5'd0, 12'h000, 3'd0), 1'b1, ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL seq_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL seq_write: got %h@%h, expected %h@%h", o.data, o.addr, e.data, e.addr);
            end
        end
        n_checks++;
        if ({done, word_count} !== {1'b1, 11'd3}) begin
            n_fail++;
            $display("FAIL seq_status: done=%b count=%0d, expected 1/3", done, word_count);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        fld_t bad[9];
        logic ok;
        bad[0] = mk(TYPE_LDI, 5'd5, 5'd0, 12'h012, 3'd0);
        bad[1] = mk(TYPE_BRBS, 5'd0, 5'd0, 12'h040, 3'd2);
        bad[2] = mk(TYPE_BRBC, 5'd0, 5'd0, 12'hF80, 3'd2);
        bad[3] = mk(TYPE_LDS, 5'd16, 5'd0, 12'h0C5, 3'd0);
        bad[4] = mk(TYPE_STS, 5'd0, 5'd3, 12'h045, 3'd0);
        bad[5] = mk(TYPE_LDI, 5'd20, 5'd0, 12'h1A5, 3'd0);
        bad[6] = mk(TYPE_UNKNOWN, 5'd1, 5'd2, 12'h000, 3'd0);
        bad[7] = mk(opcode_t'(0), 5'd1, 5'd2, 12'h000, 3'd0);
        bad[8] = mk(TYPE_ADD | TYPE_ADC, 5'd1, 5'd2, 12'h000, 3'd0);
        for (int i = 0; i < 9; i++) begin
            obs_q.delete();
            do_start(10'h020);
            send(bad[i], 1'b1, ok);
            repeat (3) @(posedge clk);
            #1;
            n_checks++;
            if ({ok, err, bus.in_ready, done} !== 4'b1100 || obs_q.size() != 0) begin
                n_fail++;
                $display("FAIL illegal_%0d: ok=%b err=%b ready=%b done=%b writes=%0d, expected 1/1/0/0/0",
                         i, ok, err, bus.in_ready, done, obs_q.size());
            end
        end
        do_start(10'h020);
        n_checks++;
        if ({err, bus.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_clear: err=%b ready=%b, expected 0/1", err, bus.in_ready);
        end
        send(mk(TYPE_NOP, 5'd0, 5'd0, 12'h000, 3'd0), 1'b1, ok);
        repeat (3) @(posedge clk);
        obs_q.delete();
    endtask

    task automatic test_wrap();
        logic ok;
        wr_t  e, o;
        do_start(10'h3FF);
        exp_q.push_back({10'h3FF, 16'h0000});
        exp_q.push_back({10'h000, 16'h0000});
        send(mk(TYPE_NOP, 5'd7, 5'd9, 12'h123, 3'd5), 1'b0, ok);
        send(mk(TYPE_NOP, 5'd0, 5'd0, 12'h000, 3'd0), 1'b1, ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_write: got %h@%h, expected %h@%h", o.data, o.addr, e.data, e.addr);
            end
        end
        n_checks++;
        if ({wrap, word_count, done, err} !== {1'b1, 11'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_status: wrap=%b count=%0d done=%b err=%b, expected 1/2/1/0",
                     wrap, word_count, done, err);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_write();
        logic ok;
        do_start(10'h050);
        send(mk(TYPE_NOP, 5'd0, 5'd0, 12'h000, 3'd0), 1'b0, ok);
        send(mk(TYPE_MOV, 5'd3, 5'd4, 12'h000, 3'd0), 1'b0, ok);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({pm_we, bus.in_ready, done, word_count} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_write: pm_we=%b ready=%b done=%b count=%0d, expected all 0",
                     pm_we, bus.in_ready, done, word_count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_roundtrip();
        localparam int N = 60;
        logic       ok;
        fld_t       f, d;
        wr_t        o;
        logic [3:0] m;
        int         hs_fail;
        hs_fail = 0;
        do_start(10'h200);
        for (int i = 0; i < N; i++) begin
            f = rand_legal(type_of(i % 20));
            fld_q.push_back(f);
            send(f, (i == N - 1), ok);
            if (!ok) hs_fail++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (hs_fail != 0 || obs_q.size() != N || err !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_run: timeouts=%0d writes=%0d err=%b done=%b, expected 0/%0d/0/1",
                     hs_fail, obs_q.size(), err, done, N);
        end
        for (int k = 0; k < N && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            f = fld_q.pop_front();
            d = decode(o.data);
            m = use_mask(f.t);
            n_checks++;
            if (d.t !== f.t || o.addr !== 10'(10'h200 + k)
                || (m[3] && d.rd !== f.rd) || (m[2] && d.rr !== f.rr)
                || (m[1] && d.imd !== f.imd) || (m[0] && d.b !== f.b)) begin
                n_fail++;
                $display("FAIL rt_%0d: word %h@%h decodes to t=%h rd=%0d rr=%0d imd=%h b=%0d, required t=%h rd=%0d rr=%0d imd=%h b=%0d@%h (mask %b)",
                         k, o.data, o.addr, d.t, d.rd, d.rr, d.imd, d.b,
                         f.t, f.rd, f.rr, f.imd, f.b, 10'(10'h200 + k), m);
            end
        end
        fld_q.delete(); obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_type  = '0;
        bus.in_rd    = '0;
        bus.in_rr    = '0;
        bus.in_imd   = '0;
        bus.in_bit   = '0;
        test_reset();
        test_single_add();
        test_sequences();
        test_illegal();
        test_wrap();
        test_reset_mid_write();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
